// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pipe_state_e;

  localparam int REG_X0 = 0;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exme;
    logic mewb;
  } stall_vec_t;

  localparam stall_vec_t STALL_NONE = stall_vec_t'(5'b00000);
  localparam stall_vec_t STALL_ALL  = stall_vec_t'(5'b11111);

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// rtl/pipe_hazard_ctrl_load_use_detect.sv - load-use comparator between ID sources and EX load destination
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_memread,
  output logic              o_hit
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never produces a dependency
  assign w_rd_live = i_ex_memread && (i_ex_rd != REG_AW'(REG_X0));
  assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hit     = w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage core with data-memory timeout
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_memread,
  input  logic              i_ex_br_taken,
  input  logic              i_me_mem_access,
  input  logic              i_dmem_ack,
  output logic              o_dmem_req,
  output logic              o_stall_pc,
  output logic              o_stall_ifid,
  output logic              o_stall_idex,
  output logic              o_stall_exme,
  output logic              o_stall_mewb,
  output logic              o_flush_ifid,
  output logic              o_flush_idex,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]  o_stall_cycles,
  output logic [CNT_W-1:0]  o_flush_count,
`endif
  output logic              o_mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  pipe_state_e r_state;
  pipe_state_e w_state_nxt;
  logic [CW-1:0] r_wcnt;
  logic [CW-1:0] w_wcnt_nxt;
  logic r_mem_err;
  logic w_err_set;
  logic w_mem_stall;
  logic w_req;
  logic w_lu_hit;
  stall_vec_t w_stall;
  logic w_flush_ifid;
  logic w_flush_idex;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use (
    .i_id_rs1     (i_id_rs1),
    .i_id_rs2     (i_id_rs2),
    .i_id_use_rs1 (i_id_use_rs1),
    .i_id_use_rs2 (i_id_use_rs2),
    .i_ex_rd      (i_ex_rd),
    .i_ex_memread (i_ex_memread),
    .o_hit        (w_lu_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_wcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_mem_err <= r_mem_err | w_err_set;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_mem_stall = 1'b0;
    w_req       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      RUN: begin
        w_req = i_me_mem_access;
        if (i_me_mem_access && !i_dmem_ack) begin
          w_mem_stall = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_wcnt_nxt  = CW'(1);
        end
      end
      MEM_WAIT: begin
        w_req = 1'b1;
        if (i_dmem_ack) begin
          w_state_nxt = RUN;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == CW'(MEM_TIMEOUT)) begin
          w_mem_stall = 1'b1;
          w_state_nxt = ERR;
          w_err_set   = 1'b1;
        end else begin
          w_mem_stall = 1'b1;
          w_wcnt_nxt  = r_wcnt + CW'(1);
        end
      end
      ERR: begin
        w_mem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // A held branch is re-evaluated on the ack cycle, when every stage advances again
  always_comb begin
    w_stall      = STALL_NONE;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    if (w_mem_stall) begin
      w_stall = STALL_ALL;
    end else if (i_ex_br_taken) begin
      w_flush_ifid = 1'b1;
      w_flush_idex = 1'b1;
    end else if (w_lu_hit) begin
      w_stall.pc   = 1'b1;
      w_stall.ifid = 1'b1;
      w_flush_idex = 1'b1;
    end
  end

  assign o_dmem_req   = rst & w_req;
  assign o_stall_pc   = rst & w_stall.pc;
  assign o_stall_ifid = rst & w_stall.ifid;
  assign o_stall_idex = rst & w_stall.idex;
  assign o_stall_exme = rst & w_stall.exme;
  assign o_stall_mewb = rst & w_stall.mewb;
  assign o_flush_ifid = rst & w_flush_ifid;
  assign o_flush_idex = rst & w_flush_idex;
  assign o_mem_err    = r_mem_err;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Both counters saturate rather than wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((|w_stall) && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_idex && !(&r_flush_count)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed vectors
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int TMO = 4;

  // {dmem_req, stall_pc, stall_ifid, stall_idex, stall_exme, stall_mewb, flush_ifid, flush_idex, mem_err}
  localparam logic [8:0] E_NONE = 9'b0_00000_00_0;
  localparam logic [8:0] E_REQ  = 9'b1_00000_00_0;
  localparam logic [8:0] E_RSTL = 9'b1_11111_00_0;
  localparam logic [8:0] E_LU   = 9'b0_11000_01_0;
  localparam logic [8:0] E_BR   = 9'b0_00000_11_0;
  localparam logic [8:0] E_RQBR = 9'b1_00000_11_0;
  localparam logic [8:0] E_ERR  = 9'b0_11111_00_1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_br_taken = 0;
  logic me_mem_access = 0, dmem_ack = 0;
  logic dmem_req, stall_pc, stall_ifid, stall_idex, stall_exme, stall_mewb;
  logic flush_ifid, flush_idex, mem_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int model_stalls = 0;
  int model_flushes = 0;
  logic [8:0] exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW      (AW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_id_rs1        (id_rs1),
    .i_id_rs2        (id_rs2),
    .i_id_use_rs1    (id_use_rs1),
    .i_id_use_rs2    (id_use_rs2),
    .i_ex_rd         (ex_rd),
    .i_ex_memread    (ex_memread),
    .i_ex_br_taken   (ex_br_taken),
    .i_me_mem_access (me_mem_access),
    .i_dmem_ack      (dmem_ack),
    .o_dmem_req      (dmem_req),
    .o_stall_pc      (stall_pc),
    .o_stall_ifid    (stall_ifid),
    .o_stall_idex    (stall_idex),
    .o_stall_exme    (stall_exme),
    .o_stall_mewb    (stall_mewb),
    .o_flush_ifid    (flush_ifid),
    .o_flush_idex    (flush_idex),
`ifdef PIPE_PERF_CNT_EN
    .o_stall_cycles  (stall_cycles),
    .o_flush_count   (flush_count),
`endif
    .o_mem_err       (mem_err)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      logic [8:0] a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = {dmem_req, stall_pc, stall_ifid, stall_idex, stall_exme, stall_mewb,
           flush_ifid, flush_idex, mem_err};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", nm, a, e);
      end
    end
  end

  task automatic apply(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic u1, input logic u2, input logic [AW-1:0] rd,
                       input logic mr, input logic br, input logic ma, input logic ack,
                       input logic [8:0] exp, input string nm);
    @(posedge clk);
    #1;
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_memread = mr; ex_br_taken = br;
    me_mem_access = ma; dmem_ack = ack;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    if (rst && (|exp[7:3])) model_stalls++;
    if (rst && exp[1]) model_flushes++;
  endtask

  task automatic idle(input logic [8:0] exp, input string nm);
    apply('0, '0, 0, 0, '0, 0, 0, 0, 0, exp, nm);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_br_taken = 0;
    me_mem_access = 0; dmem_ack = 0;
    exp_q.push_back(E_NONE);
    name_q.push_back(nm);
    model_stalls = 0;
    model_flushes = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset forces outputs low even with every event asserted
    apply(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0, E_NONE, "reset_forced");
    idle(E_NONE, "reset_idle");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load-use
    apply(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, E_LU, "lu_rs2_hit");
    apply(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, E_REQ, "lu_release_zero_wait");
    apply(5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 0, E_NONE, "lu_x0");
    apply(5'd7, 5'd3, 0, 1, 5'd7, 1, 0, 0, 0, E_NONE, "lu_rs1_unused");
    apply(5'd7, 5'd3, 1, 0, 5'd7, 1, 0, 0, 0, E_LU, "lu_rs1_hit");
    apply(5'd7, 5'd3, 1, 1, 5'd9, 1, 0, 0, 0, E_NONE, "lu_no_match");
    apply(5'd7, 5'd3, 1, 1, 5'd7, 0, 0, 0, 0, E_NONE, "lu_not_load");

    // Branch beats load-use
    apply(5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, E_BR, "br_over_lu");
    idle(E_NONE, "br_done");

    // Memory wait of three cycles
    apply('0, '0, 0, 0, '0, 0, 0, 1, 0, E_RSTL, "mw_c0");
    apply('0, '0, 0, 0, '0, 0, 0, 1, 0, E_RSTL, "mw_c1");
    apply('0, '0, 0, 0, '0, 0, 0, 1, 0, E_RSTL, "mw_c2");
    apply('0, '0, 0, 0, '0, 0, 0, 1, 1, E_REQ, "mw_ack");
    idle(E_NONE, "mw_back_to_run");

    // Zero-wait access
    apply('0, '0, 0, 0, '0, 0, 0, 1, 1, E_REQ, "zero_wait");
    idle(E_NONE, "zero_wait_run");

    // Branch held during memory wait, load-use also suppressed
    apply('0, '0, 0, 0, '0, 0, 1, 1, 0, E_RSTL, "brw_c0");
    apply(5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 1, 0, E_RSTL, "brw_c1_lu_masked");
    apply('0, '0, 0, 0, '0, 0, 1, 1, 1, E_RQBR, "brw_release_flush");
    idle(E_NONE, "brw_done");

`ifdef PIPE_PERF_CNT_EN
    @(posedge clk);
    #1;
    n_checks++;
    if (stall_cycles !== 32'(model_stalls)) begin
      n_fail++;
      $display("FAIL perf_stall_cycles: got %0d expected %0d", stall_cycles, model_stalls);
    end
    n_checks++;
    if (flush_count !== 32'(model_flushes)) begin
      n_fail++;
      $display("FAIL perf_flush_count: got %0d expected %0d", flush_count, model_flushes);
    end
`endif

    // Reset in the middle of a wait
    apply('0, '0, 0, 0, '0, 0, 0, 1, 0, E_RSTL, "mid_c0");
    apply('0, '0, 0, 0, '0, 0, 0, 1, 0, E_RSTL, "mid_c1");
    do_reset("mid_wait_reset");
    idle(E_NONE, "mid_wait_run");

    // Timeout into ERR
    apply('0, '0, 0, 0, '0, 0, 0, 1, 0, E_RSTL, "tmo_c0");
    for (int i = 1; i <= TMO; i++) begin
      apply('0, '0, 0, 0, '0, 0, 0, 1, 0, E_RSTL, $sformatf("tmo_c%0d", i));
    end
    idle(E_ERR, "tmo_err");
    apply(5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 1, 1, E_ERR, "err_sticky");
    do_reset("err_reset");
    idle(E_NONE, "err_cleared_run");
    apply('0, '0, 0, 0, '0, 0, 0, 1, 1, E_REQ, "err_cleared_zero_wait");
    idle(E_NONE, "final_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
